// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one eth_tx frame transmitter between two packet sources.
// Routes the granted source for one frame; a watchdog aborts frames that never complete.
module eth_tx_arbiter #(
    parameter int unsigned MAX_FRAME_CYCLES = 8192,
    parameter int unsigned BYTE_LEN         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic                src0_inclk,
    input  logic                src1_inclk,
    input  logic [BYTE_LEN-1:0] src0_in,
    input  logic [BYTE_LEN-1:0] src1_in,
    input  logic                src0_done,
    input  logic                src1_done,
    output logic                grant0,
    output logic                grant1,
    output logic                src0_readclk,
    output logic                src1_readclk,
    output logic                src0_abort,
    output logic                src1_abort,
    output logic                tx_start,
    output logic                tx_rst,
    output logic                tx_inclk,
    output logic [BYTE_LEN-1:0] tx_in,
    output logic                tx_in_done,
    input  logic                tx_upstream_readclk,
    input  logic                tx_done,
    output logic                busy
);

    localparam int unsigned     WD_W    = $clog2(MAX_FRAME_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_FRAME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, ACTIVE, ABORT} state_t;

    state_t          state_q;
    logic [1:0]      grant_q;
    logic            last_q;
    logic [WD_W-1:0] wd_q;
    logic [1:0]      pick;

    // Both requesting: the source not served last wins.
    always_comb begin
        pick = {req1, req0};
        if (req0 && req1) pick = last_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q <= pick;
                        state_q <= START;
                    end
                end
                START: begin
                    wd_q    <= '0;
                    state_q <= ACTIVE;
                end
                ACTIVE: begin
                    wd_q <= wd_q + 1'b1;
                    if (tx_done) begin
                        grant_q <= '0;
                        last_q  <= grant_q[1];
                        state_q <= IDLE;
                    end else if (wd_q == WD_LAST) begin
                        state_q <= ABORT;
                    end
                end
                ABORT: begin
                    grant_q <= '0;
                    last_q  <= grant_q[1];
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Everything except tx_rst is forced low while rst is held, even before the state has cleared.
    logic run, active, abort_st;
    assign run      = !rst;
    assign active   = run && (state_q == ACTIVE);
    assign abort_st = run && (state_q == ABORT);

    assign grant0       = run && grant_q[0];
    assign grant1       = run && grant_q[1];
    assign tx_start     = run && (state_q == START);
    assign busy         = run && (state_q != IDLE);
    assign tx_rst       = rst || abort_st;
    assign src0_abort   = abort_st && grant_q[0];
    assign src1_abort   = abort_st && grant_q[1];
    assign src0_readclk = active && grant_q[0] && tx_upstream_readclk;
    assign src1_readclk = active && grant_q[1] && tx_upstream_readclk;
    assign tx_inclk     = active && ((grant_q[0] && src0_inclk) || (grant_q[1] && src1_inclk));
    assign tx_in_done   = active && ((grant_q[0] && src0_done) || (grant_q[1] && src1_done));

    always_comb begin
        tx_in = '0;
        if (active && grant_q[0]) tx_in = src0_in;
        else if (active && grant_q[1]) tx_in = src1_in;
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: expected grants and bytes are queued as stimulus
// is driven and compared when the DUT issues tx_start / tx_inclk.
module tb_eth_tx_arbiter;

    localparam int unsigned MAXC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       src0_inclk = 1'b0, src1_inclk = 1'b0;
    logic [7:0] src0_in = '0, src1_in = '0;
    logic       src0_done = 1'b0, src1_done = 1'b0;
    logic       tx_upstream_readclk = 1'b0, tx_done = 1'b0;
    logic       grant0, grant1, src0_readclk, src1_readclk, src0_abort, src1_abort;
    logic       tx_start, tx_rst, tx_inclk, tx_in_done, busy;
    logic [7:0] tx_in;

    eth_tx_arbiter #(.MAX_FRAME_CYCLES(MAXC), .BYTE_LEN(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .src0_inclk(src0_inclk), .src1_inclk(src1_inclk),
        .src0_in(src0_in), .src1_in(src1_in),
        .src0_done(src0_done), .src1_done(src1_done),
        .grant0(grant0), .grant1(grant1),
        .src0_readclk(src0_readclk), .src1_readclk(src1_readclk),
        .src0_abort(src0_abort), .src1_abort(src1_abort),
        .tx_start(tx_start), .tx_rst(tx_rst),
        .tx_inclk(tx_inclk), .tx_in(tx_in), .tx_in_done(tx_in_done),
        .tx_upstream_readclk(tx_upstream_readclk), .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -100;
    int abort_cnt = 0;
    logic [1:0] exp_grant[$];
    logic [8:0] exp_byte[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard side: pops expectations when the DUT produces output.
    always @(negedge clk) begin
        if (tx_start) begin
            if (exp_grant.size() == 0) check("start_unexpected", 1, 0);
            else check("grant_at_start", {grant1, grant0}, exp_grant.pop_front());
            check("start_gap_ge2", ((cyc - last_done) >= 2), 1);
            check("no_start_with_txrst", tx_rst, 0);
        end
        if (tx_inclk) begin
            if (exp_byte.size() == 0) check("byte_unexpected", 1, 0);
            else check("tx_byte", {tx_in_done, tx_in}, exp_byte.pop_front());
        end
        if (grant0 && grant1) check("grant_onehot", {grant1, grant0}, 2'b00);
        if (tx_done && busy) last_done = cyc;
        if (src0_abort || src1_abort) abort_cnt++;
    end

    task automatic clear_srcs();
        src0_inclk = 1'b0; src1_inclk = 1'b0;
        src0_in = '0; src1_in = '0;
        src0_done = 1'b0; src1_done = 1'b0;
        tx_upstream_readclk = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_txrst", tx_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", {grant1, grant0}, 2'b00);
        check("rst_start", tx_start, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_txrst", tx_rst, 0);
        check("post_rst_busy", busy, 0);
    endtask

    task automatic wait_start(output int s);
        bit seen = 0;
        s = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_start) begin
                seen = 1;
                s = cyc;
                break;
            end
        end
        check("start_seen", seen, 1);
    endtask

    // Streams n bytes from src with noise on the other source, then ends the frame with tx_done.
    task automatic stream(input int src, input int n);
        logic [7:0] b;
        logic       dn, rc;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            b  = 8'($urandom_range(0, 255));
            dn = (i == n - 1);
            rc = 1'($urandom_range(0, 1));
            if (src == 0) begin
                src0_inclk = 1'b1; src0_in = b; src0_done = dn;
                src1_inclk = 1'b1; src1_in = ~b; src1_done = 1'b1;
            end else begin
                src1_inclk = 1'b1; src1_in = b; src1_done = dn;
                src0_inclk = 1'b1; src0_in = ~b; src0_done = 1'b1;
            end
            tx_upstream_readclk = rc;
            exp_byte.push_back({dn, b});
            @(negedge clk);
            check("readclk_granted", (src == 0) ? src0_readclk : src1_readclk, rc);
            check("readclk_other", (src == 0) ? src1_readclk : src0_readclk, 0);
        end
        @(posedge clk); #1;
        clear_srcs();
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        check("done_busy_low", busy, 0);
        check("done_grant_low", {grant1, grant0}, 2'b00);
    endtask

    initial begin
        int s, t, ac, a0;
        bit seen;

        do_reset();

        // Single request, 46-byte payload.
        @(posedge clk); #1 req0 = 1'b1;
        t = cyc;
        exp_grant.push_back(2'b01);
        wait_start(s);
        check("start_latency", s - t, 1);
        check("single_busy", busy, 1);
        req0 = 1'b0;
        stream(0, 46);

        // Contention after reset: 0,1,0,1.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        wait_start(s); stream(0, 4);
        wait_start(s); stream(1, 4);
        wait_start(s); stream(0, 4);
        wait_start(s); req0 = 1'b0; req1 = 1'b0; stream(1, 4);

        // Starvation: req0 held, req1 raised during a source-0 frame.
        req0 = 1'b1;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10); exp_grant.push_back(2'b01);
        wait_start(s); req1 = 1'b1; stream(0, 4);
        wait_start(s); req1 = 1'b0; stream(1, 4);
        wait_start(s); req0 = 1'b0; stream(0, 4);

        // Watchdog expiry without tx_done.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        wait_start(s);
        req0 = 1'b0;
        seen = 0; ac = 0;
        for (int k = 0; k < int'(MAXC) + 10; k++) begin
            @(negedge clk);
            if (src0_abort || src1_abort) begin
                seen = 1; ac = cyc;
                check("abort_txrst", tx_rst, 1);
                check("abort_which", {src1_abort, src0_abort}, 2'b01);
                break;
            end
        end
        check("abort_seen", seen, 1);
        check("abort_cycle", ac - s, MAXC + 1);
        @(negedge clk);
        check("abort_one_cycle", src0_abort, 0);
        check("abort_txrst_drop", tx_rst, 0);

        // Source 1 next; tx_done coincides with expiry and must win.
        wait_start(s);
        req1 = 1'b0;
        while (cyc < s + int'(MAXC)) begin
            @(posedge clk); #1;
        end
        a0 = abort_cnt;
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        check("sameexp_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("sameexp_no_abort", abort_cnt, a0);

        // Serve source 0 so last points at 0, then reset mid-frame.
        req0 = 1'b1;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b01);
        wait_start(s); req0 = 1'b0; stream(0, 3);
        req0 = 1'b1;
        wait_start(s); req0 = 1'b0;
        @(posedge clk); #1;
        src0_inclk = 1'b1; src0_in = 8'h5a; src0_done = 1'b0;
        exp_byte.push_back({1'b0, 8'h5a});
        @(negedge clk);
        a0 = abort_cnt;
        @(posedge clk); #1 rst = 1'b1;
        tx_upstream_readclk = 1'b1;
        @(negedge clk);
        check("midrst_txrst", tx_rst, 1);
        check("midrst_inclk_gated", tx_inclk, 0);
        check("midrst_readclk_gated", src0_readclk, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_grant", {grant1, grant0}, 2'b00);
        check("midrst_busy", busy, 0);
        check("midrst_routed", {tx_inclk, tx_in_done, tx_in, src0_readclk, src1_readclk}, 0);
        check("midrst_no_abort", abort_cnt, a0);
        clear_srcs();
        req0 = 1'b1; req1 = 1'b1;
        exp_grant.push_back(2'b01);
        wait_start(s); req0 = 1'b0; req1 = 1'b0; stream(0, 3);

        repeat (3) @(negedge clk);
        check("sb_grants_drained", exp_grant.size(), 0);
        check("sb_bytes_drained", exp_byte.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares one `eth_tx` frame transmitter between two packet sources, e.g. the crypto payload path and a control/ARP path. The block arbitrates frame requests round-robin and issues the single-cycle `start` to `eth_tx`. For the duration of one frame it routes the granted source's byte stream, `in_done`, and the `upstream_readclk` read strobes. A watchdog aborts any frame that fails to complete, so a stuck source cannot hold the transmitter.

## Interface
Parameters:
- `MAX_FRAME_CYCLES`, default 8192: cycles allowed in ACTIVE before abort. Must be ≥ 2.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: level request to send one frame. The source holds it until its grant.
- `src0_inclk`, `src1_inclk` in 1: source byte valid.
- `src0_in`, `src1_in` in `BYTE_LEN`: source payload byte.
- `src0_done`, `src1_done` in 1: source's last payload byte, with `in_done` semantics.
- `grant0`, `grant1` out 1: registered, one-hot or zero.
- `src0_readclk`, `src1_readclk` out 1: routed payload read strobe.
- `src0_abort`, `src1_abort` out 1: one-cycle pulse; the granted source's frame was killed.
- `tx_start` out 1: to `eth_tx.start`.
- `tx_rst` out 1: to `eth_tx.rst`; equals `rst || abort pulse`.
- `tx_inclk`, `tx_in[BYTE_LEN]`, `tx_in_done` out: to `eth_tx` `inclk`/`in`/`in_done`.
- `tx_upstream_readclk` in 1: from `eth_tx.upstream_readclk`.
- `tx_done` in 1: from `eth_tx.done`, asserted at the end of the inter-frame gap.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, START, ACTIVE, ABORT. Registers: `state`, `grant[1:0]`, `last` (index last served), `wd` watchdog counter of width `clog2(MAX_FRAME_CYCLES)`.
- **IDLE**
  - If any `req`: pick a winner, set its `grant`, go to START.
  - Winner when both request: the index ≠ `last`. Winner when one requests: that one.
- **START**
  - `tx_start`=1 for exactly this cycle; clear `wd` and go to ACTIVE.
- **ACTIVE**
  - Muxes are active only in this state; in every other state all routed outputs are 0.
  - `tx_inclk`=granted `srcN_inclk`.
  - `tx_in`=granted `srcN_in`; 0 when no grant.
  - `tx_in_done`=granted `srcN_done`.
  - `srcN_readclk`=`grantN && tx_upstream_readclk`. Non-granted sources see 0 on all routed outputs.
  - `wd` increments each cycle.
  - On `tx_done`: clear `grant`, set `last` to the served index, go to IDLE.
  - Else if `wd == MAX_FRAME_CYCLES-1`: go to ABORT.
- **ABORT** (one cycle)
  - `tx_rst`=1 and `srcN_abort`=1 for the granted N.
  - Clear `grant`, set `last` to the aborted index, go to IDLE.
- `req` is sampled only in IDLE. Dropping `req` after grant does not cancel the frame.
- Reset: state IDLE, `grant`=0, `last`=1 (source 0 wins the first contention), `wd`=0. All outputs are 0 except `tx_rst`=1 while `rst` is high.
- `rst` mid-frame: return to IDLE next cycle and drop grants. No `srcN_abort` pulse; the sources share `rst`.

## Timing
- `req` high in IDLE at cycle t: `grant` high at t+1 with `tx_start`=1 at t+1, ACTIVE from t+2.
- Routing is combinational: zero added latency on `inclk`/`in`/`in_done`/`readclk`. `eth_tx` PACKET_SYNTH_ROM_LATENCY is unchanged.
- `tx_done` at cycle d: `grant` low and IDLE at d+1. The next `tx_start` comes no earlier than d+2.
- `tx_done` and watchdog expiry in the same cycle: `tx_done` wins, no abort.
- Watchdog: with no `tx_done`, ABORT occupies cycle s+1+MAX_FRAME_CYCLES, where `tx_start` was at s.
- `grant0 && grant1` is never true. `tx_start` and `tx_rst` are never high in the same cycle except under `rst`.

## Test plan
- Single request: `req0`=1 at t=10 → `grant0`, `tx_start` at 11. A 46-byte payload is passed through byte-for-byte; `src0_readclk` mirrors `tx_upstream_readclk`. `tx_done` at d → `grant0`=0, `busy`=0 at d+1.
- Contention after reset: `req0`=`req1`=1 held → frames served 0,1,0,1. No overlap; each `tx_start` is ≥2 cycles after the prior `tx_done`. `src1_readclk` stays 0 during source-0 frames.
- Starvation check: `req0` held continuously, `req1` raised mid-frame of source 0 → the next grant goes to source 1.
- Watchdog: `MAX_FRAME_CYCLES`=16, `tx_done` never asserted → ABORT 17 cycles after `tx_start`, with `tx_rst`=1 and `src0_abort`=1 for one cycle. The next grant is source 1 if requesting. Same-cycle `tx_done` at expiry → no abort.
- Reset mid-ACTIVE: `rst` pulse → next cycle `grant`=0, `busy`=0, all routed outputs 0, no abort pulse. Source 0 wins the next contention.
- Full chain with `eth_tx`: the dibit output shows preamble/SFD, source bytes, and a correct CRC32, checked against a software model for both sources.
